// File: rtl/bloom_arbiter.sv
// bloom_arbiter: arbitrates two lookup ports and one insert (cfg) port onto a
// shared hash engine and a 1-bit bloom BRAM, one operation in flight.
// Optional hash watchdog is compiled in with `define BLOOM_ARB_TIMEOUT_EN.
module bloom_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int HASH_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   input  logic [103:0]      req_key0,
   input  logic [103:0]      req_key1,
   output logic [1:0]        req_ready,
   output logic [1:0]        rsp_valid,
   output logic              rsp_hit,
   output logic              rsp_err,
   input  logic [1:0]        rsp_ready,
   input  logic              cfg_valid,
   input  logic [103:0]      cfg_key,
   output logic              cfg_ready,
   output logic              cfg_err,
   output logic              hash_start,
   output logic [103:0]      hash_key,
   input  logic              hash_valid,
   input  logic [ADDR_W-1:0] hash_idx,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_wdata,
   input  logic              bram_rdata,
   output logic              busy
);

   // Wide enough to hold HASH_TIMEOUT, so the saturated value never aliases 0.
   localparam int CNT_W = $clog2(HASH_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, HASH, MEM, LATCH, RESP} state_t;

   state_t            state_q, state_d;
   logic [103:0]      key_q;
   logic [ADDR_W-1:0] idx_q;
   logic              op_cfg_q;    // current operation is an insert
   logic              owner_q;     // lookup port that owns the response
   logic              rr_last_q;   // port granted by the last lookup accept
   logic              hit_q;
   logic [CNT_W-1:0]  cnt_q;       // HASH cycles elapsed, 0 in the start cycle
   logic              grant_cfg, grant_req, grant_port;
   logic              hash_first, hash_done;

   assign hash_first = (cnt_q == '0);
   assign hash_done  = (state_q == HASH) && !hash_first && hash_valid;
   assign hash_key   = key_q;
   assign rsp_hit    = hit_q;

`ifdef BLOOM_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HASH_TIMEOUT - 1);
   logic hash_expired;
   logic err_q, cfg_err_q;

   // A real hash result in the last allowed cycle still wins over the watchdog.
   assign hash_expired = (state_q == HASH) && !hash_done && (cnt_q == CNT_LAST);
   assign rsp_err      = err_q;
   assign cfg_err      = cfg_err_q;

   // Watchdog flags: sticky lookup error until the next lookup accept, one-cycle insert abort.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= hash_expired && op_cfg_q;
         if (hash_expired && !op_cfg_q)
            err_q <= 1'b1;
         else if (grant_req)
            err_q <= 1'b0;
      end
   end
`else
   assign rsp_err = 1'b0;
   assign cfg_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: registers use <= so every flop samples pre-edge values, independent of statement order.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, grant and datapath-control decode.
   always_comb begin
      // NOTE: every signal written here is defaulted first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      req_ready  = 2'b00;
      cfg_ready  = 1'b0;
      grant_cfg  = 1'b0;
      grant_req  = 1'b0;
      grant_port = 1'b0;
      hash_start = 1'b0;
      bram_en    = 1'b0;
      bram_we    = 1'b0;
      bram_wdata = 1'b0;
      bram_addr  = '0;
      rsp_valid  = 2'b00;
      busy       = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (rst_n) begin
               if (cfg_valid) begin
                  cfg_ready = 1'b1;
                  grant_cfg = 1'b1;
                  state_d   = HASH;
               end else if (req_valid != 2'b00) begin
                  grant_port = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
                  req_ready  = grant_port ? 2'b10 : 2'b01;
                  grant_req  = 1'b1;
                  state_d    = HASH;
               end
            end
         end
         HASH: begin
            hash_start = hash_first;
            if (hash_done) state_d = MEM;
`ifdef BLOOM_ARB_TIMEOUT_EN
            else if (hash_expired) state_d = op_cfg_q ? IDLE : RESP;
`endif
         end
         MEM: begin
            bram_en    = 1'b1;
            bram_we    = op_cfg_q;
            bram_wdata = op_cfg_q;
            bram_addr  = idx_q;
            state_d    = op_cfg_q ? IDLE : LATCH;
         end
         LATCH: state_d = RESP;
         RESP: begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
            if (rsp_ready[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operation context: key, owner, round-robin pointer, hash index, hit, HASH cycle count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_q     <= '0;
         idx_q     <= '0;
         op_cfg_q  <= 1'b0;
         owner_q   <= 1'b0;
         rr_last_q <= 1'b1;
         hit_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (grant_cfg) begin
            key_q    <= cfg_key;
            op_cfg_q <= 1'b1;
            cnt_q    <= '0;
         end else if (grant_req) begin
            key_q     <= grant_port ? req_key1 : req_key0;
            op_cfg_q  <= 1'b0;
            owner_q   <= grant_port;
            rr_last_q <= grant_port;
            cnt_q     <= '0;
         end else if (state_q == HASH && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (hash_done)        idx_q <= hash_idx;
         if (state_q == LATCH) hit_q <= bram_rdata;
`ifdef BLOOM_ARB_TIMEOUT_EN
         if (hash_expired && !op_cfg_q) hit_q <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_bloom_arbiter.sv
// tb_bloom_arbiter: directed scoreboard bench for bloom_arbiter.
// Lookups push their expected response into exp_q; a monitor pops on each
// rsp_valid/rsp_ready handshake. Build with +define+BLOOM_ARB_TIMEOUT_EN to
// exercise the watchdog branch.
module tb_bloom_arbiter;
   localparam int ADDR_W = 10;

   localparam logic [103:0] K0 = {72'h06_C0A8_0001_0A00_0001, 16'd1000, 16'd80};
   localparam logic [103:0] K1 = {72'h11_C0A8_0002_0A00_0002, 16'd2000, 16'd53};
   localparam logic [103:0] K2 = {72'h06_AC10_0003_0A00_0003, 16'd3000, 16'd443};
   localparam logic [103:0] K3 = {72'h11_AC10_0004_0A00_0004, 16'd4000, 16'd123};
   localparam logic [103:0] K4 = {72'h06_0A01_0005_0A00_0005, 16'd5000, 16'd22};
   localparam logic [103:0] K5 = {72'h06_0A01_0006_0A00_0006, 16'd6000, 16'd25};
   localparam logic [103:0] K6 = {72'h11_0A01_0007_0A00_0007, 16'd7000, 16'd69};
   localparam logic [103:0] K7 = {72'h06_0A01_0008_0A00_0008, 16'd8000, 16'd110};
   localparam logic [103:0] K8 = {72'h06_0A01_0009_0A00_0009, 16'd9000, 16'd143};
   localparam logic [103:0] K9 = {72'h11_0A01_000A_0A00_000A, 16'd9100, 16'd161};

   typedef struct packed {
      logic [1:0] valid;
      logic       hit;
      logic       err;
   } rsp_t;

   logic              clk, rst_n;
   logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [103:0]      req_key0, req_key1, cfg_key, hash_key;
   logic              rsp_hit, rsp_err, cfg_valid, cfg_ready, cfg_err;
   logic              hash_start, hash_valid, bram_en, bram_we, bram_wdata, bram_rdata, busy;
   logic [ADDR_W-1:0] hash_idx, bram_addr;

   int                vectors = 0;
   int                miscompares = 0;
   rsp_t              exp_q[$];
   int                hash_lat;
   logic [ADDR_W-1:0] hash_idx_v;
   logic              mem [0:(1<<ADDR_W)-1];

   bloom_arbiter #(.ADDR_W(ADDR_W), .HASH_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_key0(req_key0), .req_key1(req_key1), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
      .cfg_valid(cfg_valid), .cfg_key(cfg_key), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .hash_start(hash_start), .hash_key(hash_key), .hash_valid(hash_valid), .hash_idx(hash_idx),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
      .bram_rdata(bram_rdata), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Bloom BRAM model: cleared by reset except bit 5, read data one cycle after bram_en.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 1'b0;
         mem[5]     <= 1'b1;
         bram_rdata <= 1'b0;
      end else if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_wdata;
         else         bram_rdata     <= mem[bram_addr];
      end
   end

   // Hash engine model: hash_lat cycles after the start cycle, one-cycle hash_valid (0 = never).
   initial begin
      hash_valid = 1'b0;
      hash_idx   = '0;
      forever begin
         @(negedge clk);
         if (hash_start === 1'b1 && hash_lat > 0) begin
            repeat (hash_lat) @(posedge clk);
            #1;
            hash_valid = 1'b1;
            hash_idx   = hash_idx_v;
            @(posedge clk);
            #1;
            hash_valid = 1'b0;
         end
      end
   end

   // Response monitor: pops one expected entry per handshake.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (rsp_valid & rsp_ready) != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", rsp_valid, 2'b00);
            end else begin
               e = exp_q.pop_front();
               check("rsp_port", rsp_valid, e.valid);
               check("rsp_hit", rsp_hit, e.hit);
               check("rsp_err", rsp_err, e.err);
            end
         end
      end
   end

   // Raise a request (src 0/1 = lookup port, 2 = cfg) and wait for its accept.
   // Returns one cycle after the accept edge, just after posedge.
   task automatic issue(input int src, input logic [103:0] key, output bit ok, output int waited);
      ok = 1'b0;
      waited = 0;
      @(posedge clk);
      #1;
      if (src == 2)      begin cfg_key  = key; cfg_valid    = 1'b1; end
      else if (src == 1) begin req_key1 = key; req_valid[1] = 1'b1; end
      else               begin req_key0 = key; req_valid[0] = 1'b1; end
      for (int w = 0; w < 50 && !ok; w++) begin
         @(negedge clk);
         if ((src == 2) ? cfg_ready : req_ready[src[0]]) ok = 1'b1;
         else waited++;
      end
      if (!ok) check("accept_wait", waited, 0);
      @(posedge clk);
      #1;
      if (src == 2) cfg_valid = 1'b0;
      else          req_valid[src[0]] = 1'b0;
   endtask

   // Full lookup with cycle-exact checks; ends at the negedge of the first RESP cycle.
   task automatic lookup(input int port, input logic [103:0] key, input logic [ADDR_W-1:0] idx,
                         input logic exp_hit, input int h, output int waited);
      bit         ok;
      logic [1:0] oh;
      oh = (port == 1) ? 2'b10 : 2'b01;
      hash_lat   = h;
      hash_idx_v = idx;
      issue(port, key, ok, waited);
      if (ok) begin
         exp_q.push_back('{valid: oh, hit: exp_hit, err: 1'b0});
         for (int k = 1; k <= h + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
               check("hash_start", hash_start, 1'b1);
               check("hash_key", hash_key, key);
            end
            if (k == 2)     check("hash_start_pulse", hash_start, 1'b0);
            if (k == h + 1) check("bram_quiet", bram_en, 1'b0);
            if (k == h + 2) check("bram_read", {bram_en, bram_we, bram_addr}, {1'b1, 1'b0, idx});
            if (k == h + 4) begin
               check("rsp_timing", rsp_valid, oh);
               check("rsp_hit_timing", rsp_hit, exp_hit);
               check("hash_key_held", hash_key, key);
            end
         end
      end
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      check("drain", done, 1'b1);
   endtask

   initial begin
      int   order [3];
      int   n, waited, err_cnt;
      bit   ok, both, bram_seen, act;
      order = '{0, 1, 0};
      rst_n = 1'b0; req_valid = 2'b00; req_key0 = '0; req_key1 = '0;
      rsp_ready = 2'b11; cfg_valid = 1'b0; cfg_key = '0;
      hash_lat = 1; hash_idx_v = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_ctrl", {req_ready, rsp_valid, rsp_hit, rsp_err, cfg_ready, cfg_err,
                         hash_start, bram_en, bram_we, bram_wdata}, 12'h000);
      check("rst_addr_key", {bram_addr, hash_key}, '0);

      // Round robin with both ports held: grant order 0,1,0, never both ready.
      @(posedge clk);
      #1;
      rst_n = 1'b1; req_key0 = K0; req_key1 = K1; req_valid = 2'b11;
      hash_lat = 1; hash_idx_v = 10'h007;
      n = 0; both = 1'b0;
      for (int c = 0; c < 200 && n < 3; c++) begin
         @(negedge clk);
         if (req_ready == 2'b11) both = 1'b1;
         if (req_ready != 2'b00) begin
            check("rr_grant", req_ready[1], order[n][0]);
            exp_q.push_back('{valid: (order[n] == 1) ? 2'b10 : 2'b01, hit: 1'b0, err: 1'b0});
            n++;
         end
      end
      check("rr_count", n, 3);
      check("rr_never_both", both, 1'b0);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      drain();

      // Basic hit: port 0, hash after 2 cycles, idx 0x005.
      lookup(0, K5, 10'h005, 1'b1, 2, waited);
      drain();

      // cfg preempts lookup; insert writes 0x3FF; lookup accepted right after.
      hash_lat = 1; hash_idx_v = 10'h3FF;
      @(posedge clk);
      #1;
      cfg_key = K2; cfg_valid = 1'b1; req_key0 = K3; req_valid[0] = 1'b1;
      @(negedge clk);
      check("pri_cfg_ready", cfg_ready, 1'b1);
      check("pri_req_held", req_ready, 2'b00);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      check("ins_hash_key", hash_key, K2);
      check("ins_req_blocked", req_ready, 2'b00);
      @(negedge clk);
      @(negedge clk);
      check("ins_write", {bram_en, bram_we, bram_wdata, bram_addr}, {3'b111, 10'h3FF});
      lookup(0, K3, 10'h3FF, 1'b1, 1, waited);
      check("lookup_after_ins", waited, 0);
      drain();

      // Response backpressure: only the non-owner ready is high for 10 cycles.
      rsp_ready = 2'b01;
      lookup(1, K4, 10'h005, 1'b1, 1, waited);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 2'b10);
         check("hold_hit", rsp_hit, 1'b1);
         check("hold_req_ready", req_ready, 2'b00);
         check("hold_busy", busy, 1'b1);
      end
      @(posedge clk);
      #1;
      rsp_ready = 2'b11; req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("release_idle", {busy, rsp_valid}, 3'b000);
      drain();

      // Hash never answers.
      hash_lat = 0;
`ifdef BLOOM_ARB_TIMEOUT_EN
      issue(0, K8, ok, waited);
      if (ok) begin
         exp_q.push_back('{valid: 2'b01, hit: 1'b0, err: 1'b1});
         bram_seen = 1'b0;
         for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bram_en) bram_seen = 1'b1;
            if (k == 8) check("wd_not_early", rsp_valid, 2'b00);
            if (k == 9) check("wd_rsp", {rsp_valid, rsp_hit, rsp_err}, {2'b01, 1'b0, 1'b1});
         end
         check("wd_no_bram", bram_seen, 1'b0);
      end
      drain();
      issue(2, K9, ok, waited);
      err_cnt = 0; bram_seen = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (cfg_err) err_cnt++;
         if (bram_en) bram_seen = 1'b1;
      end
      check("wd_cfg_err_pulse", err_cnt, 1);
      check("wd_cfg_no_write", bram_seen, 1'b0);
      check("wd_cfg_idle", busy, 1'b0);
`else
      issue(0, K8, ok, waited);
      act = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy || rsp_valid != 2'b00 || rsp_err || cfg_err) act = 1'b0;
      end
      check("nowd_stuck", act, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`endif

      // Reset while in HASH; the late hash_valid must be ignored.
      hash_lat = 4; hash_idx_v = 10'h005;
      issue(1, K6, ok, waited);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      act = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bram_en || rsp_valid != 2'b00 || busy || cfg_err) act = 1'b1;
      end
      check("reset_abandon", act, 1'b0);
      lookup(0, K7, 10'h005, 1'b1, 1, waited);
      check("post_reset_accept", waited, 0);
      drain();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bloom_arbiter.md
BLOOM_ARBITER -- requirements
Module: bloom_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, bloom BRAM bit-address width (hash index width).
REQ-002 Parameter: HASH_TIMEOUT, 64, hash-wait watchdog limit in cycles, used only with BLOOM_ARB_TIMEOUT_EN.
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  2  lookup request per port.
- req_key0, req_key1  in  104 each  {ip_protocol[71:0], src_port[15:0], dst_port[15:0]}.
- req_ready  out  2  lookup accept per port.
- rsp_valid  out  2  one-hot lookup response.
- rsp_hit  out  1  bloom hit, qualified by rsp_valid.
- rsp_err  out  1  response produced by watchdog.
- rsp_ready  in  2  response accept per port.
- cfg_valid  in  1  insert request.
- cfg_key  in  104  insert key.
- cfg_ready  out  1  insert accept.
- cfg_err  out  1  one-cycle pulse, insert aborted.
- hash_start  out  1  one-cycle start to the shared hash engine.
- hash_key  out  104  held key.
- hash_valid  in  1  hash done.
- hash_idx  in  ADDR_W  hash result.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  1  BRAM write data.
- bram_rdata  in  1  read data, valid the cycle after bram_en.
- busy  out  1  high when state is not IDLE.

Function
REQ-005 FSM states SHALL be IDLE, HASH, MEM, LATCH, RESP; one operation in flight.
REQ-006 IDLE grant priority SHALL be cfg_valid first, then the lookup ports round-robin. The port not granted last wins when both are valid.
REQ-007 req_ready and cfg_ready SHALL be combinational, high only in IDLE and only for the winner. The accepting cycle SHALL latch key and owner, then go to HASH.
REQ-008 The round-robin pointer SHALL update only on a lookup accept. cfg SHALL strictly preempt lookups, and lookup starvation under continuous cfg_valid is permitted.
REQ-009 hash_start SHALL be high only in the first HASH cycle. hash_key SHALL be stable from that cycle until IDLE.
REQ-010 hash_valid SHALL be sampled only in HASH cycles after the hash_start cycle, and ignored in every other state. On hash_valid: latch hash_idx, go to MEM.
REQ-011 MEM lookup SHALL drive bram_en=1, we=0, addr=idx for one cycle, then LATCH. LATCH SHALL register bram_rdata into rsp_hit, then RESP.
REQ-012 MEM insert SHALL drive bram_en=1, we=1, wdata=1, addr=idx for one cycle, then IDLE. An insert produces no response.
REQ-013 RESP SHALL hold rsp_valid[owner], rsp_hit and rsp_err stable until rsp_ready[owner]. The handshake cycle goes to IDLE, and a new accept is earliest the next cycle. rsp_ready of the non-owner SHALL be ignored.
REQ-014 Lookup latency: accept at T, hash_valid at T+1+H (H>=1), rsp_valid from T+4+H.
REQ-015 bram_en, bram_we and hash_start SHALL be 0 outside the states above. A req_valid dropped before accept SHALL have no effect.

Reset
REQ-016 While rst_n=0 at a clk edge: state IDLE, pointer set so port 0 wins first, all outputs 0, counters 0.
REQ-017 Reset mid-operation SHALL abandon the operation: no response, no BRAM access afterwards, no cfg_err.

Configuration
REQ-018 The macro BLOOM_ARB_TIMEOUT_EN SHALL enable the hash watchdog.
- With the macro: after HASH_TIMEOUT HASH cycles (counted from the hash_start cycle) without hash_valid, a lookup goes to RESP with rsp_hit=0, rsp_err=1. An insert goes to IDLE with no write and a one-cycle cfg_err.
- Without the macro: HASH waits indefinitely, and rsp_err and cfg_err are tied 0.

Verification
REQ-019 Lookup port0 accepted at T, hash_valid at T+3, idx=0x005, bram_rdata=1 -> bram read addr 0x005 at T+4; rsp_valid=2'b01, hit=1, err=0 at T+6.
REQ-020 Both req_valid held high after reset for three transactions -> grant order 0,1,0, and req_ready is never 2'b11.
REQ-021 cfg_valid and req_valid[0] both high, hash_idx=0x3FF -> cfg accepted first, write addr 0x3FF we=1 wdata=1; lookup accepted the cycle after return to IDLE.
REQ-022 rsp_ready low for 10 cycles in RESP -> rsp_valid and rsp_hit stable, req_ready=0, busy=1; release -> IDLE next cycle.
REQ-023 HASH_TIMEOUT=8, no hash_valid, accept at T:
- With the macro: rsp_valid, hit=0, err=1 at T+9.
- Without the macro: busy=1 and no response after 100 cycles.
REQ-024 rst_n=0 for one cycle while in HASH, then hash_valid -> IDLE, no bram_en, no rsp_valid, next accept normal.
